// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings,
// width helpers and a saturating counter increment.
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) ($clog2(x))
`endif

package uart_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCEPT  = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo NUM_REQ.
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = `CLOG2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  always_comb begin
    logic [IDW-1:0] cand;
    cand  = '0;
    idx_o = ptr_i;
    any_o = |req_i;
    // Walk from the farthest offset back to the pointer so the closest hit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[cand]) begin
        idx_o = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one uart_tx serializer between
// NUM_REQ byte-stream requesters; a grant lasts a whole packet.
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       tx_rdy,
  output logic                       tx_new_data,
  output logic [WIDTH-1:0]           tx_char,
  output logic                       grant_valid,
  output logic [`CLOG2(NUM_REQ)-1:0] grant_id
);

  localparam int IDW = `CLOG2(NUM_REQ);

  logic [2:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0] char_q, char_d;
  logic             last_q, last_d;
  logic [7:0]       burst_q, burst_d;
  logic [7:0]       gap_q, gap_d;

  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             own_valid;
  logic             own_last;
  logic [WIDTH-1:0] own_data;
  logic [7:0]       gap_inc;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == IDW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign gap_inc = sat_inc8(gap_q);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gid_d       = gid_q;
    char_d      = char_q;
    last_d      = last_q;
    burst_d     = burst_q;
    gap_d       = gap_q;
    req_ready   = '0;
    tx_new_data = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_any && tx_rdy) begin
          gid_d   = pick_idx;
          burst_d = 8'd0;
          gap_d   = 8'd0;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (own_valid) begin
          req_ready[gid_q] = 1'b1;
          char_d           = own_data;
          last_d           = own_last;
          burst_d          = sat_inc8(burst_q);
          gap_d            = 8'd0;
          state_d          = S_ISSUE;
        end else begin
          gap_d = gap_inc;
          if (gap_inc >= 8'(GAP_CYCLES)) begin
            state_d = S_RELEASE;
          end
        end
      end
      S_ISSUE: begin
        // Never start a frame the serializer cannot take.
        if (tx_rdy) begin
          tx_new_data = 1'b1;
          state_d     = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!tx_rdy) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_rdy) begin
          if (last_q || (burst_q >= 8'(MAX_BURST))) begin
            state_d = S_RELEASE;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      S_RELEASE: begin
        rr_ptr_d = (gid_q == IDW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      char_q   <= '0;
      last_q   <= 1'b0;
      burst_q  <= 8'd0;
      gap_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      char_q   <= char_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      gap_q    <= gap_d;
    end
  end

  assign grant_valid = (state_q == S_ACCEPT) || (state_q == S_ISSUE) ||
                       (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);
  assign grant_id    = gid_q;
  assign tx_char     = char_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a behavioural
// serializer model (rdy low for FRAME cycles after each start pulse).
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int FRAME = 40;
  localparam int GAP   = 32;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_rdy;
  logic              tx_new_data;
  logic [W-1:0]      tx_char;
  logic              grant_valid;
  logic [1:0]        grant_id;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  logic [7:0] qmem  [NREQ][32];
  logic       qlast [NREQ][32];
  int         head  [NREQ];
  int         tail  [NREQ];

  logic [7:0] sent_b  [64];
  logic [1:0] sent_id [64];
  int         n_sent;
  int         busy;
  bit         force_busy;
  bit         rr_seen;
  bit         nd_seen;

  uart_tx_arbiter #(
    .NUM_REQ    (NREQ),
    .WIDTH      (W),
    .MAX_BURST  (16),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_rdy      (tx_rdy),
    .tx_new_data (tx_new_data),
    .tx_char     (tx_char),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*W +: W]    = qmem[i][head[i]];
        req_last[i]           = qlast[i][head[i]];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*W +: W]    = '0;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  task automatic enqueue(input int r, input logic [7:0] b, input logic l);
    if (tail[r] < 32) begin
      qmem[r][tail[r]]  = b;
      qlast[r][tail[r]] = l;
      tail[r]++;
    end
  endtask

  task automatic clear_log();
    n_sent = 0;
    for (int i = 0; i < 64; i++) begin
      sent_b[i]  = '0;
      sent_id[i] = '0;
    end
  endtask

  // One clock: record pre-edge activity, advance, update models and drive.
  task automatic tick();
    logic [NREQ-1:0] hs;
    logic            nd;
    hs = req_valid & req_ready;
    nd = tx_new_data;
    if ($countones(req_ready) > 1) viol++;
    if (nd && !tx_rdy) viol++;
    if (|req_ready) rr_seen = 1'b1;
    if (nd) begin
      nd_seen = 1'b1;
      if (n_sent < 64) begin
        sent_b[n_sent]  = tx_char;
        sent_id[n_sent] = grant_id;
        n_sent++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) head[i]++;
    end
    if (nd) busy = FRAME;
    else if (busy > 0) busy--;
    tx_rdy = (busy == 0) && !force_busy;
    drive_reqs();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive_reqs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int max, input string nm);
    int k;
    k = 0;
    while (n_sent < n && k < max) begin
      tick();
      k++;
    end
    checks++;
    if (n_sent < n) begin
      errors++;
      $display("FAIL %s timeout: sent=%0d need=%0d", nm, n_sent, n);
    end
  endtask

  task automatic wait_idle(input int max, input string nm);
    int k;
    k = 0;
    while ((grant_valid || !tx_rdy) && k < max) begin
      tick();
      k++;
    end
    checks++;
    if (grant_valid || !tx_rdy) begin
      errors++;
      $display("FAIL %s idle timeout: grant_valid=%0b tx_rdy=%0b", nm, grant_valid, tx_rdy);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    force_busy = 1'b0;
    busy       = 0;
    tx_rdy     = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    clear_log();
    drive_reqs();
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++;
    if (tx_new_data !== 1'b0) begin errors++; $display("FAIL reset_tx_new_data got=%b exp=0", tx_new_data); end
    checks++;
    if (tx_char !== 8'h00) begin errors++; $display("FAIL reset_tx_char got=%h exp=00", tx_char); end
    checks++;
    if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid got=%b exp=0", grant_valid); end
    checks++;
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_b [5];
    logic [1:0] exp_i [5];
    int k;
    do_reset();
    clear_log();
    enqueue(0, 8'h48, 1'b0);
    enqueue(0, 8'h69, 1'b0);
    enqueue(0, 8'h0A, 1'b1);
    drive_reqs();
    tick();
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_latency_ready got=%b exp=0001", req_ready); end
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      errors++; $display("FAIL single_grant got=%b/%0d exp=1/0", grant_valid, grant_id);
    end
    tick();
    checks++;
    if (tx_new_data !== 1'b1 || tx_char !== 8'h48) begin
      errors++; $display("FAIL single_latency_issue got nd=%b char=%h exp nd=1 char=48", tx_new_data, tx_char);
    end
    wait_sent(3, 300, "single_bytes");
    k = 0;
    while (!tx_rdy && k < 100) begin tick(); k++; end
    checks++;
    if (grant_valid !== 1'b1) begin errors++; $display("FAIL single_hold_at_stop got=%b exp=1", grant_valid); end
    tick();
    checks++;
    if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_release_after_stop got=%b exp=0", grant_valid); end
    // Pointer now sits at 1: requester 1 must beat requester 0.
    enqueue(0, 8'h01, 1'b1);
    enqueue(1, 8'h02, 1'b1);
    tick();
    wait_sent(5, 300, "single_ptr_bytes");
    exp_b[0] = 8'h48; exp_i[0] = 2'd0;
    exp_b[1] = 8'h69; exp_i[1] = 2'd0;
    exp_b[2] = 8'h0A; exp_i[2] = 2'd0;
    exp_b[3] = 8'h02; exp_i[3] = 2'd1;
    exp_b[4] = 8'h01; exp_i[4] = 2'd0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sent_b[i] !== exp_b[i] || sent_id[i] !== exp_i[i]) begin
        errors++;
        $display("FAIL single_seq[%0d] got=%h/id%0d exp=%h/id%0d", i, sent_b[i], sent_id[i], exp_b[i], exp_i[i]);
      end
    end
    wait_idle(200, "single_end");
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_b [5];
    logic [1:0] exp_i [5];
    do_reset();
    clear_log();
    enqueue(0, 8'hA0, 1'b0);
    enqueue(0, 8'hA1, 1'b1);
    enqueue(0, 8'hA2, 1'b0);
    enqueue(0, 8'hA3, 1'b1);
    enqueue(2, 8'h55, 1'b1);
    drive_reqs();
    wait_sent(5, 600, "rr_bytes");
    exp_b[0] = 8'hA0; exp_i[0] = 2'd0;
    exp_b[1] = 8'hA1; exp_i[1] = 2'd0;
    exp_b[2] = 8'h55; exp_i[2] = 2'd2;
    exp_b[3] = 8'hA2; exp_i[3] = 2'd0;
    exp_b[4] = 8'hA3; exp_i[4] = 2'd0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sent_b[i] !== exp_b[i] || sent_id[i] !== exp_i[i]) begin
        errors++;
        $display("FAIL rr_seq[%0d] got=%h/id%0d exp=%h/id%0d", i, sent_b[i], sent_id[i], exp_b[i], exp_i[i]);
      end
    end
    wait_idle(200, "rr_end");
  endtask

  task automatic test_burst_cap();
    logic [7:0] eb;
    logic [1:0] ei;
    do_reset();
    clear_log();
    for (int i = 0; i < 20; i++) enqueue(1, 8'h10 + 8'(i), 1'b0);
    enqueue(3, 8'hC3, 1'b1);
    drive_reqs();
    wait_sent(21, 3000, "burst_bytes");
    for (int i = 0; i < 21; i++) begin
      if (i < 16) begin eb = 8'h10 + 8'(i); ei = 2'd1; end
      else if (i == 16) begin eb = 8'hC3; ei = 2'd3; end
      else begin eb = 8'h10 + 8'(i - 1); ei = 2'd1; end
      checks++;
      if (sent_b[i] !== eb || sent_id[i] !== ei) begin
        errors++;
        $display("FAIL burst_seq[%0d] got=%h/id%0d exp=%h/id%0d", i, sent_b[i], sent_id[i], eb, ei);
      end
    end
    wait_idle(200, "burst_end");
  endtask

  task automatic test_gap_timeout();
    int k;
    int n;
    do_reset();
    clear_log();
    enqueue(0, 8'h77, 1'b0);
    drive_reqs();
    wait_sent(1, 50, "gap_byte");
    k = 0;
    while (!tx_rdy && k < 100) begin tick(); k++; end
    nd_seen = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant_valid && n < 100);
    checks++;
    if (n !== GAP + 1) begin errors++; $display("FAIL gap_release_cycles got=%0d exp=%0d", n, GAP + 1); end
    checks++;
    if (nd_seen !== 1'b0) begin errors++; $display("FAIL gap_no_new_data got=%b exp=0", nd_seen); end
    checks++;
    if (n_sent !== 1) begin errors++; $display("FAIL gap_sent_count got=%0d exp=1", n_sent); end
    wait_idle(200, "gap_end");
  endtask

  task automatic test_reset_mid_byte();
    int k;
    do_reset();
    clear_log();
    enqueue(1, 8'h21, 1'b1);
    drive_reqs();
    wait_sent(1, 50, "rstmid_first");
    wait_idle(200, "rstmid_first_idle");
    enqueue(2, 8'h31, 1'b1);
    drive_reqs();
    wait_sent(2, 50, "rstmid_second");
    k = 0;
    while (tx_rdy && k < 20) begin tick(); k++; end
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (grant_valid !== 1'b0 || req_ready !== 4'b0000 || tx_new_data !== 1'b0 ||
        tx_char !== 8'h00 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got gv=%b rdy=%b nd=%b char=%h id=%0d exp all 0",
               grant_valid, req_ready, tx_new_data, tx_char, grant_id);
    end
    rst = 1'b0;
    // Pointer must be back at 0, so requester 1 beats requester 3.
    enqueue(1, 8'h41, 1'b1);
    enqueue(3, 8'h43, 1'b1);
    drive_reqs();
    wait_sent(4, 400, "rstmid_after");
    checks++;
    if (sent_b[2] !== 8'h41 || sent_id[2] !== 2'd1) begin
      errors++; $display("FAIL rstmid_next_grant got=%h/id%0d exp=41/id1", sent_b[2], sent_id[2]);
    end
    checks++;
    if (sent_b[3] !== 8'h43 || sent_id[3] !== 2'd3) begin
      errors++; $display("FAIL rstmid_then got=%h/id%0d exp=43/id3", sent_b[3], sent_id[3]);
    end
    wait_idle(200, "rstmid_end");
  endtask

  task automatic test_tx_busy();
    do_reset();
    clear_log();
    force_busy = 1'b1;
    tx_rdy     = 1'b0;
    rr_seen    = 1'b0;
    nd_seen    = 1'b0;
    enqueue(0, 8'h5A, 1'b1);
    drive_reqs();
    repeat (10) tick();
    checks++;
    if (rr_seen !== 1'b0) begin errors++; $display("FAIL busy_no_ready got=%b exp=0", rr_seen); end
    checks++;
    if (nd_seen !== 1'b0) begin errors++; $display("FAIL busy_no_new_data got=%b exp=0", nd_seen); end
    force_busy = 1'b0;
    wait_sent(1, 100, "busy_release");
    checks++;
    if (sent_b[0] !== 8'h5A || sent_id[0] !== 2'd0) begin
      errors++; $display("FAIL busy_byte got=%h/id%0d exp=5A/id0", sent_b[0], sent_id[0]);
    end
    wait_idle(200, "busy_end");
  endtask

  task automatic test_invariants();
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL invariants violations got=%0d exp=0", viol);
    end
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_burst_cap();
    test_gap_timeout();
    test_reset_mid_byte();
    test_tx_busy();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single uart_tx serializer between NUM_REQ byte-stream requesters using round-robin arbitration.
- A grant is held for a whole packet (up to req_last, a burst cap or a gap timeout), so packets from different requesters never interleave on the wire.
- Sits between client logic (heartbeat reporter, rx echo path, status writers) and the uart_tx instance; drives its new_data/char and watches its rdy.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, character width; must match uart_tx WIDTH
- MAX_BURST, 16, max bytes per grant before forced release (1..255)
- GAP_CYCLES, 32, idle cycles tolerated mid-packet before forced release (1..255)

Ports:
- clk  input  1  system clock (pin3_clk_16mhz at top level)
- rst  input  1  synchronous active-high reset
- req_valid  input  NUM_REQ  requester i has a byte on its data slice
- req_data  input  NUM_REQ*WIDTH  byte for requester i at bits [i*WIDTH +: WIDTH]
- req_last  input  NUM_REQ  byte is the last of the packet; qualified by req_valid
- req_ready  output  NUM_REQ  one-hot; byte i is taken when req_valid[i]&req_ready[i]
- tx_rdy  input  1  uart_tx rdy
- tx_new_data  output  1  one-cycle start pulse to uart_tx new_data
- tx_char  output  WIDTH  to uart_tx char; stable from pulse until tx_rdy falls
- grant_valid  output  1  a requester currently owns the transmitter
- grant_id  output  clog2(NUM_REQ)  owner index; meaningful only when grant_valid=1

Behaviour:
- Reset (synchronous, any state): state=IDLE, rr_ptr=0, req_ready=0, tx_new_data=0, tx_char=0, grant_valid=0, grant_id=0, burst_cnt=0, gap_cnt=0. Reset mid-byte abandons the byte; uart_tx finishes on its own.
- Round robin: search i = rr_ptr, rr_ptr+1, ... mod NUM_REQ; the first i with req_valid[i] wins. On release, rr_ptr = grant_id+1 mod NUM_REQ.
- IDLE: if any req_valid and tx_rdy=1, latch the winner; grant_valid=1, burst_cnt=0; go to ACCEPT next cycle. If tx_rdy=0, stay.
- ACCEPT: if req_valid[g], assert req_ready[g] for exactly this cycle, latch tx_char=req_data slice, latch last_q=req_last[g], burst_cnt+=1, gap_cnt=0, go to ISSUE. Otherwise gap_cnt+=1; at gap_cnt==GAP_CYCLES go to RELEASE.
- ISSUE: tx_new_data=1 for one cycle; go to WAIT_LO.
- WAIT_LO: wait for tx_rdy=0 (uart_tx took the byte); go to WAIT_HI. tx_char is held throughout.
- WAIT_HI: wait for tx_rdy=1 (stop bit done). Then:
  - if last_q or burst_cnt==MAX_BURST, go to RELEASE;
  - else go to ACCEPT.
- RELEASE: grant_valid=0, update rr_ptr; go to IDLE. There is one idle cycle between grants.
- Latency: from req_valid in IDLE (tx_rdy=1) to req_ready is 1 cycle; to tx_new_data is 2 cycles.
- Invariants:
  - req_ready is never asserted outside ACCEPT and is at most one-hot.
  - tx_new_data is never asserted while tx_rdy=0.
- Requester dropping req_valid without last: handled by the gap timeout; no byte is lost or duplicated.
- Simultaneous events:
  - a new requester rising during a grant waits for release;
  - the owner's req_valid during WAIT states is ignored until ACCEPT.
- Counters: burst_cnt and gap_cnt are 8-bit and saturate; they are never compared past their limits.

Decomposition:
- Shared package uart_pkg: state encodings (IDLE, ACCEPT, ISSUE, WAIT_LO, WAIT_HI, RELEASE), the CLOG2 macro, WIDTH default.
- One sub-module rr_pick: purely combinational; inputs req vector and pointer; outputs winner index and any_valid.
- The FSM, counters and latches stay in the top-level module.

Test Plan:
- Single requester 0 sends the 3-byte packet 0x48,0x69,0x0A with last on 0x0A, through a real uart_tx at DIV=4 -> serial line shows the 3 frames in order; grant_valid is low 1 cycle after the stop bit of 0x0A; rr_ptr=1.
- Requesters 0 and 2 both valid at reset release -> 0 is served first; 2's single byte 0x55 follows after RELEASE; then 0 again if still valid; no interleaving.
- Requester 1 streams 20 bytes with no last, MAX_BURST=16 -> release after byte 16; requester 3 (waiting) is granted next; the remaining 4 bytes of requester 1 are sent later.
- Requester 0 sends one byte, then drops req_valid with no last -> release exactly GAP_CYCLES cycles after entering ACCEPT; no tx_new_data during the gap.
- Assert rst during WAIT_HI -> next cycle all outputs are 0 and state is IDLE; the following request is granted normally from rr_ptr=0.
- Hold tx_rdy=0 (serializer busy) with requests pending -> no req_ready and no tx_new_data until tx_rdy=1.
